divisor_sequencial: RTL and testbench

Iterative restoring divider for the RV64 datapath, producing DIV/DIVU/REM/REMU results one quotient bit per clock. It sits beside the ULA as its multi-cycle counterpart: it takes the same two operands from the register file and hands a single registered result back to writeback, using a start/valid handshake. Signed operations use magnitudes internally, with sign correction in a final cycle. RISC-V divide-by-zero and overflow results are produced exactly as the ISA defines them.

---
 rtl/ula_pkg.sv | 16 +
 rtl/divisor_passo.sv | 27 ++
 rtl/divisor_sequencial.sv | 160 ++++++++++++++++
 tb/tb_divisor_sequencial.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA-side datapath: divider FSM states and width constants.
package ula_pkg;

  localparam int BITS_PADRAO = 64;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    AJUSTE  = 2'd2
  } estado_div_t;

  // ISA-mandated results for divide-by-zero quotient and signed overflow.
  localparam logic [BITS_PADRAO-1:0] QUOCIENTE_DIV_ZERO = {BITS_PADRAO{1'b1}};
  localparam logic [BITS_PADRAO-1:0] MAIS_NEGATIVO      = {1'b1, {(BITS_PADRAO-1){1'b0}}};

endpackage

// File: rtl/divisor_passo.sv
// One restoring-division step: shift one dividend bit into the partial remainder and
// subtract |divisor| when it fits.
module divisor_passo
  import ula_pkg::*;
#(
  parameter int BITS = BITS_PADRAO
) (
  input  logic [BITS-1:0] resto,
  input  logic            bit_in,
  input  logic [BITS-1:0] divisor_abs,
  output logic [BITS-1:0] resto_prox,
  output logic            bit_quoc
);

  logic [BITS:0] deslocado;
  logic [BITS:0] tentativa;

  // The shifted remainder needs BITS+1 bits: for unsigned divisors with the MSB set the
  // partial remainder itself may already use all BITS bits.
  assign deslocado = {resto, bit_in};
  assign tentativa = deslocado - {1'b0, divisor_abs};

  // Both operands are below 2*|divisor|, so the top bit of the trial is its sign.
  assign bit_quoc   = ~tentativa[BITS];
  assign resto_prox = bit_quoc ? tentativa[BITS-1:0] : deslocado[BITS-1:0];

endmodule

// File: rtl/divisor_sequencial.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Define DIVISOR_ATALHO_EN to resolve divide-by-zero and signed overflow without iterating.
module divisor_sequencial
  import ula_pkg::*;
#(
  parameter int BITS = BITS_PADRAO
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inicio,
  input  logic [BITS-1:0] dividendo,
  input  logic [BITS-1:0] divisor,
  input  logic            com_sinal,
  input  logic            resto_sel,
  output logic            ocupado,
  output logic            valido,
  output logic [BITS-1:0] dout
);

  localparam int              CW        = $clog2(BITS);
  localparam logic [CW-1:0]   ULTIMA    = CW'(BITS - 1);
  localparam logic [BITS-1:0] TODOS_UNS = QUOCIENTE_DIV_ZERO[BITS_PADRAO-1 -: BITS];
  localparam logic [BITS-1:0] MIN_NEG   = MAIS_NEGATIVO[BITS_PADRAO-1 -: BITS];

  estado_div_t     estado, estado_prox;
  logic [CW-1:0]   cont;
  logic [BITS-1:0] resto_q;
  logic [BITS-1:0] quoc_q;
  logic [BITS-1:0] div_abs_q;
  logic [BITS-1:0] dividendo_q;
  logic            sel_resto_q;
  logic            neg_quoc_q;
  logic            neg_resto_q;
  logic            div_zero_q;
  logic            overflow_q;

  logic            neg_dividendo, neg_divisor;
  logic            div_zero_in, overflow_in;
  logic [BITS-1:0] dividendo_abs, divisor_abs;

  logic [BITS-1:0] resto_prox;
  logic            bit_quoc;
  logic [BITS-1:0] quoc_final, resto_final, resultado;

  // Operand decode, only meaningful in the cycle inicio is accepted.
  assign neg_dividendo = com_sinal & dividendo[BITS-1];
  assign neg_divisor   = com_sinal & divisor[BITS-1];
  assign dividendo_abs = neg_dividendo ? -dividendo : dividendo;
  assign divisor_abs   = neg_divisor ? -divisor : divisor;
  assign div_zero_in   = (divisor == '0);
  assign overflow_in   = com_sinal & (dividendo == MIN_NEG) & (divisor == TODOS_UNS);

  // The quotient register doubles as the dividend shifter: its MSB feeds the step
  // while the new quotient bit enters at the LSB.
  divisor_passo #(
    .BITS (BITS)
  ) u_passo (
    .resto       (resto_q),
    .bit_in      (quoc_q[BITS-1]),
    .divisor_abs (div_abs_q),
    .resto_prox  (resto_prox),
    .bit_quoc    (bit_quoc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= OCIOSO;
    end else begin
      estado <= estado_prox;
    end
  end

  // NOTE: the default assignment first keeps this block purely combinational; any
  // path that skipped it would infer a latch.
  always_comb begin
    estado_prox = estado;
    case (estado)
      OCIOSO: begin
        if (inicio) begin
`ifdef DIVISOR_ATALHO_EN
          estado_prox = (div_zero_in || overflow_in) ? AJUSTE : CALCULA;
`else
          estado_prox = CALCULA;
`endif
        end
      end
      CALCULA: begin
        if (cont == ULTIMA) begin
          estado_prox = AJUSTE;
        end
      end
      AJUSTE:  estado_prox = OCIOSO;
      default: estado_prox = OCIOSO;
    endcase
  end

  assign ocupado = (estado != OCIOSO);

  // NOTE: operand storage is reset along with control so an aborted request leaves no
  // stale data observable; these are flops, not a RAM, so the reset costs nothing extra.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont        <= '0;
      resto_q     <= '0;
      quoc_q      <= '0;
      div_abs_q   <= '0;
      dividendo_q <= '0;
      sel_resto_q <= 1'b0;
      neg_quoc_q  <= 1'b0;
      neg_resto_q <= 1'b0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
      valido      <= 1'b0;
      dout        <= '0;
    end else begin
      valido <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            cont        <= '0;
            resto_q     <= '0;
            quoc_q      <= dividendo_abs;
            div_abs_q   <= divisor_abs;
            dividendo_q <= dividendo;
            sel_resto_q <= resto_sel;
            neg_quoc_q  <= neg_dividendo ^ neg_divisor;
            neg_resto_q <= neg_dividendo;
            div_zero_q  <= div_zero_in;
            overflow_q  <= overflow_in;
          end
        end
        CALCULA: begin
          resto_q <= resto_prox;
          quoc_q  <= {quoc_q[BITS-2:0], bit_quoc};
          cont    <= cont + CW'(1);
        end
        AJUSTE: begin
          dout   <= resultado;
          valido <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sign correction and ISA overrides; the overrides win over the iterated values.
  always_comb begin
    quoc_final  = neg_quoc_q ? -quoc_q : quoc_q;
    resto_final = neg_resto_q ? -resto_q : resto_q;
    resultado   = sel_resto_q ? resto_final : quoc_final;
    if (div_zero_q) begin
      resultado = sel_resto_q ? dividendo_q : TODOS_UNS;
    end else if (overflow_q) begin
      resultado = sel_resto_q ? '0 : MIN_NEG;
    end
  end

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial: arithmetic reference model with a latency
// countdown, compared every cycle, plus literal results for the ISA corner cases.
module tb_divisor_sequencial;

  localparam int          BITS   = 64;
  localparam int          LIMITE = 200;
  localparam logic [63:0] MINV   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] UNS    = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DIVISOR_ATALHO_EN
  localparam int LAT_ESPECIAL = 1;
`else
  localparam int LAT_ESPECIAL = 65;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inicio;
  logic [63:0] dividendo, divisor;
  logic        com_sinal, resto_sel;
  logic        ocupado, valido;
  logic [63:0] dout;

  int n_checks = 0;
  int n_pass   = 0;
  logic monitor_on = 1'b0;

  divisor_sequencial dut (
    .clk       (clk),
    .reset     (reset),
    .inicio    (inicio),
    .dividendo (dividendo),
    .divisor   (divisor),
    .com_sinal (com_sinal),
    .resto_sel (resto_sel),
    .ocupado   (ocupado),
    .valido    (valido),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nome, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nome, got, exp, $time);
  endtask

  // RISC-V division semantics from plain integer arithmetic.
  function automatic logic [63:0] modelo(input logic [63:0] a, input logic [63:0] b,
                                         input logic s, input logic r);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (b == 64'd0) return r ? a : UNS;
    if (s) begin
      if (a == MINV && b == UNS) return r ? 64'd0 : MINV;
      sa = a;
      sb = b;
      return r ? 64'(sa % sb) : 64'(sa / sb);
    end
    ua = a;
    ub = b;
    return r ? ua % ub : ua / ub;
  endfunction

  function automatic int latencia(input logic [63:0] a, input logic [63:0] b, input logic s);
`ifdef DIVISOR_ATALHO_EN
    if (b == 64'd0 || (s && a == MINV && b == UNS)) return 1;
`endif
    return BITS + 1;
  endfunction

  // Reference: idle/busy with a countdown to the valido edge.
  logic        m_busy, m_valid;
  logic [63:0] m_dout, m_res;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_valid = 1'b0; m_dout = '0; m_left = 0;
    end else begin
      m_valid = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_valid = 1'b1; m_dout = m_res;
        end
      end else if (inicio) begin
        m_busy = 1'b1;
        m_left = latencia(dividendo, divisor, com_sinal);
        m_res  = modelo(dividendo, divisor, com_sinal, resto_sel);
      end
    end
  end

  always @(negedge clk) begin
    if (monitor_on) begin
      check("mon_ocupado", {63'd0, ocupado}, {63'd0, m_busy});
      check("mon_valido", {63'd0, valido}, {63'd0, m_valid});
      check("mon_dout", dout, m_dout);
    end
  end

  task automatic iniciar(input logic [63:0] a, input logic [63:0] b, input logic s, input logic r);
    @(negedge clk);
    dividendo = a; divisor = b; com_sinal = s; resto_sel = r; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  // Counts edges after the accepting edge until valido is seen; optionally drives inicio
  // with other operands at cycle pulso_em.
  task automatic aguardar(input int pulso_em, input logic [63:0] pa, input logic [63:0] pb,
                          output int n);
    n = 0;
    while (valido !== 1'b1 && n < LIMITE) begin
      if (n == pulso_em) begin
        inicio = 1'b1; dividendo = pa; divisor = pb;
      end else begin
        inicio = 1'b0;
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic op_literal(input string nome, input logic [63:0] a, input logic [63:0] b,
                            input logic s, input logic r, input logic [63:0] exp, input int lat);
    int n;
    iniciar(a, b, s, r);
    aguardar(-1, '0, '0, n);
    check({nome, "_dout"}, dout, exp);
    check({nome, "_lat"}, 64'(n), 64'(lat));
  endtask

  function automatic logic [63:0] operando();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = UNS;
      2:       v = MINV;
      3:       v = 64'($urandom_range(1, 50));
      4:       v = -64'($urandom_range(1, 50));
      5:       v = {32'd0, 32'($urandom)};
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    int n, cnt;
    logic [63:0] a, b;
    logic s, r;
    inicio = 1'b0; dividendo = '0; divisor = '0; com_sinal = 1'b0; resto_sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ocupado", {63'd0, ocupado}, 64'd0);
    check("rst_valido", {63'd0, valido}, 64'd0);
    check("rst_dout", dout, 64'd0);
    reset = 1'b0;
    monitor_on = 1'b1;

    op_literal("u100_7_q", 64'd100, 64'd7, 1'b0, 1'b0, 64'd14, 65);
    op_literal("u100_7_r", 64'd100, 64'd7, 1'b0, 1'b1, 64'd2, 65);
    op_literal("s-7_2_q", -64'd7, 64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    op_literal("s-7_2_r", -64'd7, 64'd2, 1'b1, 1'b1, UNS, 65);
    op_literal("s7_-2_q", 64'd7, -64'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    op_literal("s7_-2_r", 64'd7, -64'd2, 1'b1, 1'b1, 64'd1, 65);
    op_literal("div0_q", 64'd5, 64'd0, 1'b0, 1'b0, UNS, LAT_ESPECIAL);
    op_literal("div0_r", 64'd5, 64'd0, 1'b0, 1'b1, 64'd5, LAT_ESPECIAL);
    op_literal("div0_sr", -64'd5, 64'd0, 1'b1, 1'b1, -64'd5, LAT_ESPECIAL);
    op_literal("ovf_q", MINV, UNS, 1'b1, 1'b0, MINV, LAT_ESPECIAL);
    op_literal("ovf_r", MINV, UNS, 1'b1, 1'b1, 64'd0, LAT_ESPECIAL);
    op_literal("umax_3", UNS, 64'd3, 1'b0, 1'b0, 64'h5555_5555_5555_5555, 65);

    // A second inicio mid-operation is ignored.
    iniciar(64'd100, 64'd7, 1'b0, 1'b0);
    aguardar(10, 64'd9, 64'd3, n);
    check("ignora_dout", dout, 64'd14);
    check("ignora_lat", 64'(n), 64'd65);

    // inicio held through the valido cycle is accepted on the following edge.
    iniciar(64'd100, 64'd7, 1'b0, 1'b0);
    aguardar(64, 64'd1000, 64'd9, n);
    check("segura_a_dout", dout, 64'd14);
    @(negedge clk);
    inicio = 1'b0;
    check("segura_b_ocupado", {63'd0, ocupado}, 64'd1);
    aguardar(-1, '0, '0, n);
    check("segura_b_dout", dout, 64'd111);
    check("segura_b_lat", 64'(n), 64'd65);

    // Asynchronous reset mid-operation aborts without a result.
    iniciar(64'hDEAD_BEEF_0123_4567, 64'h1234, 1'b0, 1'b0);
    repeat (29) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async_ocupado", {63'd0, ocupado}, 64'd0);
    check("rst_async_dout", dout, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (valido) cnt++;
    end
    check("rst_sem_valido", 64'(cnt), 64'd0);
    op_literal("pos_reset", 64'd1000, 64'd10, 1'b0, 1'b0, 64'd100, 65);

    for (int i = 0; i < 40; i++) begin
      a = operando();
      b = operando();
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      iniciar(a, b, s, r);
      aguardar(-1, '0, '0, n);
      check("rand_lat", 64'(n), 64'(latencia(a, b, s)));
      check("rand_dout", dout, modelo(a, b, s, r));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
